// File: rtl/mult_job_if.sv
// mult_job_if: signal bundle around mult_job_controller.
//   in_*   : operand-pair producer (valid/ready)
//   mul_*  : connection to the 8x8 shift-add multiplier
//   out_*  : product consumer (valid/ready)
//   busy, err : status
// The master modport is the controller; the slave modport is its surroundings.
interface mult_job_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_multiplicand;
    logic [7:0]  in_multiplier;

    logic        mul_rst;
    logic [7:0]  mul_multiplicand;
    logic [7:0]  mul_multiplier;
    logic [15:0] mul_result;
    logic        mul_end_op;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;

    logic        busy;
    logic        err;

    modport master (
        input  in_valid, in_multiplicand, in_multiplier,
        input  mul_result, mul_end_op, out_ready,
        output in_ready, mul_rst, mul_multiplicand, mul_multiplier,
        output out_valid, out_result, busy, err
    );

    modport slave (
        output in_valid, in_multiplicand, in_multiplier,
        output mul_result, mul_end_op, out_ready,
        input  in_ready, mul_rst, mul_multiplicand, mul_multiplier,
        input  out_valid, out_result, busy, err
    );
endinterface

// File: rtl/mult_job_controller.sv
// mult_job_controller: queues operand pairs, runs them one at a time through
// the shift-add multiplier and hands the 16-bit products to a consumer.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mult_job_if.master (producer, multiplier and consumer signals)
// Parameters:
//   DEPTH   - operand FIFO entries (power of two, >= 2)
//   TIMEOUT - RUN cycles allowed before a job is abandoned (>= 11)
module mult_job_controller #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    mult_job_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state;

    logic [7:0]    mem_b [DEPTH];
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wd;
    logic [WW-1:0] wd_next;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = bus.in_valid && !full;
    // Pop is decided from the registered count, so a pair written this edge
    // can never be popped on the same edge.
    assign pop     = !empty && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
    assign wd_next = wd + WW'(1);

    assign bus.in_ready = !full;
    assign bus.busy     = (state != IDLE) || !empty;

    // Storage needs no reset: validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_b[wr_ptr] <= bus.in_multiplicand;
            mem_q[wr_ptr] <= bus.in_multiplier;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // mul_rst is held high everywhere except RUN, so the multiplier always
    // sees at least one reset edge between jobs and a stale end_op from the
    // previous job cannot be mistaken for completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            wd                   <= '0;
            bus.mul_rst          <= 1'b1;
            bus.mul_multiplicand <= '0;
            bus.mul_multiplier   <= '0;
            bus.out_valid        <= 1'b0;
            bus.out_result       <= '0;
            bus.err              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.mul_multiplicand <= mem_b[rd_ptr];
                        bus.mul_multiplier   <= mem_q[rd_ptr];
                        bus.mul_rst          <= 1'b0;
                        wd                   <= '0;
                        state                <= RUN;
                    end
                end
                RUN: begin
                    wd <= wd_next;
                    if (bus.mul_end_op) begin
                        bus.out_result <= bus.mul_result;
                        bus.out_valid  <= 1'b1;
                        bus.mul_rst    <= 1'b1;
                        state          <= HOLD;
                    end else if (wd_next == WW'(TIMEOUT)) begin
                        // Abandon the job silently; err stays set until rst.
                        bus.err     <= 1'b1;
                        bus.mul_rst <= 1'b1;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (pop) begin
                            bus.mul_multiplicand <= mem_b[rd_ptr];
                            bus.mul_multiplier   <= mem_q[rd_ptr];
                            bus.mul_rst          <= 1'b0;
                            wd                   <= '0;
                            state                <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_job_controller.sv
// tb_mult_job_controller: directed and randomized bench for mult_job_controller.
// A behavioural multiplier stub drives mul_result/mul_end_op; expected products
// come from a queue filled with b*q at push time and are checked at every
// consumer handshake, together with latency, throughput and hold stability.
module tb_mult_job_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_job_if bus();

    mult_job_controller #(.DEPTH(4), .TIMEOUT(15)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          m_cnt     = 0;
    logic        stub_dead = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_res  = '0;
    int          exp_q[$];
    int          hs_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: one LOAD edge plus eight RUN edges after leaving
    // reset, then end_op stays high with the product until reset.
    always @(posedge clk) begin
        if (bus.mul_rst) begin
            m_cnt          <= 0;
            bus.mul_end_op <= 1'b0;
            bus.mul_result <= '0;
        end else if (m_cnt < 9) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 8 && !stub_dead) begin
                bus.mul_end_op <= 1'b1;
                bus.mul_result <= {8'd0, bus.mul_multiplicand} * {8'd0, bus.mul_multiplier};
            end
        end
    end

    // Consumer-side scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_result", bus.out_result, prev_res);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("result", bus.out_result, exp_q.pop_front());
                hs_cyc.push_back(cyc + 1);
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_res  = bus.out_result;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_rand(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push_pair(input logic [7:0] b, input logic [7:0] q,
                             input bit expect_out, output int edge_cyc);
        int n = 0;
        bit done = 0;
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = b;
        bus.in_multiplier   = q;
        while (!done && n < 400) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (expect_out) exp_q.push_back(int'(b) * int'(q));
                @(posedge clk); #1;
                done = 1;
            end else begin
                @(posedge clk); #1;
                if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
                n++;
            end
        end
        edge_cyc = cyc;
        chk("push_accepted", done, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int c);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, bus.out_valid, 1);
        c = cyc;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.busy) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, (exp_q.size() == 0) && !bus.busy, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int e, e1, e2, c, c2, hs0;
        rst                 = 1'b1;
        bus.in_valid        = 1'b0;
        bus.in_multiplicand = '0;
        bus.in_multiplier   = '0;
        bus.out_ready       = 1'b0;
        #1;
        chk("rst_mul_rst", bus.mul_rst, 1);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mul_b", bus.mul_multiplicand, 0);
        tick(2);
        @(negedge clk) rst = 1'b0;
        tick(1);

        // Single job with nominal latency.
        bus.out_ready = 1'b1;
        push_pair(8'd13, 8'd11, 1, e);
        wait_valid("t1_valid", c);
        chk("t1_latency", c - e, 11);
        chk("t1_result", bus.out_result, 143);
        tick(1);
        chk("t1_valid_drop", bus.out_valid, 0);
        tick(2);
        chk("t1_busy_idle", bus.busy, 0);

        // Corner operands, in push order.
        push_pair(8'd255, 8'd255, 1, e);
        push_pair(8'd0, 8'd200, 1, e);
        push_pair(8'd1, 8'd1, 1, e);
        drain("corner_drain");

        // Backpressure: FIFO fills, first result held, then drain at 1/11.
        bus.out_ready = 1'b0;
        hs_cyc.delete();
        for (int i = 0; i < 5; i++)
            push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, e);
        chk("bp_in_ready_low", bus.in_ready, 0);
        fork
            push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, e2);
            begin
                tick(20);
                chk("bp_still_full", bus.in_ready, 0);
                chk("bp_holding", bus.out_valid, 1);
                bus.out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_count", hs_cyc.size(), 6);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("bp_gap", hs_cyc[i] - hs_cyc[i-1], 11);

        // Push on the very edge that pops the only queued entry.
        bus.out_ready = 1'b0;
        hs0 = hs_cyc.size();
        push_pair(8'd21, 8'd3, 1, e);
        push_pair(8'd17, 8'd5, 1, e);
        wait_valid("sim_valid", c);
        bus.out_ready = 1'b1;
        push_pair(8'd9, 8'd12, 1, e);
        chk("sim_same_edge", hs_cyc[hs_cyc.size()-1], e);
        chk("sim_in_ready", bus.in_ready, 1);
        drain("sim_drain");
        chk("sim_count", hs_cyc.size() - hs0, 3);
        chk("sim_gap", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], 11);

        // Watchdog: dead multiplier, next job must still run.
        stub_dead = 1'b1;
        push_pair(8'd20, 8'd30, 0, e1);
        push_pair(8'd6, 8'd7, 1, e2);
        c = 0;
        while (!bus.err && c < 40) begin
            @(posedge clk); #1;
            chk("wd_no_valid", bus.out_valid, 0);
            c++;
        end
        chk("wd_err", bus.err, 1);
        chk("wd_err_edge", cyc - e1, 16);
        stub_dead = 1'b0;
        wait_valid("wd_next_valid", c2);
        chk("wd_next_latency", c2 - (e1 + 17), 10);
        chk("wd_next_result", bus.out_result, 42);
        drain("wd_drain");
        chk("wd_sticky", bus.err, 1);

        // Reset in the middle of RUN with a second pair still queued.
        push_pair(8'd50, 8'd3, 1, e);
        push_pair(8'd4, 8'd5, 1, e);
        tick(4);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_mul_rst", bus.mul_rst, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_err", bus.err, 0);
        @(negedge clk) rst = 1'b0;
        tick(1);
        push_pair(8'd7, 8'd9, 1, e);
        wait_valid("post_rst_valid", c);
        chk("post_rst_latency", c - e, 11);
        chk("post_rst_result", bus.out_result, 63);
        drain("post_rst_drain");

        // Randomized jobs with random gaps and random consumer backpressure.
        hs0 = hs_cyc.size();
        rnd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, e);
            idle_rand($urandom_range(0, 14));
        end
        rnd_ready = 1'b0;
        drain("rand_drain");
        chk("rand_count", hs_cyc.size() - hs0, 12);
        chk("rand_err", bus.err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
